pmem_arbiter: RTL and testbench

- Arbitrates the single physical-memory port between the I-cache (fetch-stage misses) and the D-cache (MEM-stage misses and writebacks) of the pipelined LC-3b core.
- Serves one line-sized transaction at a time, latching the winner's address and data.
- The D-cache has priority because it is the older pipeline stage. A starvation limit guarantees fetch forward progress.

---
 rtl/lc3b_types.sv | 13 +
 rtl/pmem_arbiter.sv | 85 ++++++++
 tb/tb_pmem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word/line widths and the memory-arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Single-port physical-memory arbiter between I-cache and D-cache line traffic.
// D wins by default; a saturating starvation counter forces an I grant after STARVE_LIMIT D grants.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst_n,

  input  logic     i_pmem_read,
  input  lc3b_word i_pmem_address,
  output lc3b_line i_pmem_rdata,
  output logic     i_pmem_resp,

  input  logic     d_pmem_read,
  input  logic     d_pmem_write,
  input  lc3b_word d_pmem_address,
  input  lc3b_line d_pmem_wdata,
  output lc3b_line d_pmem_rdata,
  output logic     d_pmem_resp,

  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state;
  logic [CW-1:0] starve_cnt;
  logic          wr_q;

  logic d_req, grant_i, grant_d;

  assign d_req   = d_pmem_read | d_pmem_write;
  assign grant_i = (state == ARB_IDLE) && i_pmem_read && (!d_req || starve_cnt == LIMIT);
  assign grant_d = (state == ARB_IDLE) && !grant_i && d_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      starve_cnt   <= '0;
      wr_q         <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_i) begin
            state        <= ARB_SERVE_I;
            pmem_address <= i_pmem_address;
            starve_cnt   <= '0;
          end else if (grant_d) begin
            state        <= ARB_SERVE_D;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            // A writeback takes precedence if the D-cache raises both strobes.
            wr_q         <= d_pmem_write;
            if (i_pmem_read && starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ARB_SERVE_I: if (pmem_resp) state <= ARB_IDLE;
        ARB_SERVE_D: if (pmem_resp) state <= ARB_IDLE;
        default:     state <= ARB_IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from registered state so reset drops them at once.
  assign pmem_read    = (state == ARB_SERVE_I) || (state == ARB_SERVE_D && !wr_q);
  assign pmem_write   = (state == ARB_SERVE_D) && wr_q;

  assign i_pmem_resp  = (state == ARB_SERVE_I) && pmem_resp;
  assign d_pmem_resp  = (state == ARB_SERVE_D) && pmem_resp;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a bench-side memory responder plus hand-computed expectations.
module tb_pmem_arbiter;
  import lc3b_types::*;

  logic         clk, rst_n;
  logic         i_pmem_read, i_pmem_resp;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata, d_pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;

  pmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int           wc;
  logic [15:0]  a0, a1;
  logic         wr, ir, dr;
  logic [127:0] wd, ird, drd;

  // Memory responder: waits for a strobe, holds it lat cycles, then pulses pmem_resp.
  // Returns at the negedge following the response edge (the mandatory IDLE cycle).
  task automatic serve(input int lat, input logic [127:0] rd, input bit poke,
                       output int wcyc, output logic [15:0] addr0, output logic [15:0] addr1,
                       output logic wflag, output logic [127:0] wdat,
                       output logic iresp, output logic dresp,
                       output logic [127:0] irdat, output logic [127:0] drdat);
    wcyc = 0;
    do begin
      @(negedge clk);
      wcyc++;
    end while (!(pmem_read || pmem_write) && wcyc < 20);
    chk("serve_start", {127'd0, pmem_read | pmem_write}, 128'd1);
    addr0 = pmem_address;
    wflag = pmem_write;
    wdat  = pmem_wdata;
    if (poke) begin
      d_pmem_address = 16'hFFFF;
      d_pmem_wdata   = '1;
    end
    repeat (lat - 1) @(negedge clk);
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    addr1 = pmem_address;
    iresp = i_pmem_resp;
    dresp = d_pmem_resp;
    irdat = i_pmem_rdata;
    drdat = d_pmem_rdata;
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  logic [15:0] exp_addr [6];
  int          exp_cnt  [6];

  initial begin
    rst_n = 1'b0;
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;

    // Reset state
    #1;
    chk("rst_pmem_read",  {127'd0, pmem_read},   128'd0);
    chk("rst_pmem_write", {127'd0, pmem_write},  128'd0);
    chk("rst_resps",      {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    chk("rst_addr",       {112'd0, pmem_address}, 128'd0);
    chk("rst_wdata",      pmem_wdata, 128'd0);
    chk("rst_cnt",        {125'd0, dut.starve_cnt}, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: I-only read, 3-cycle memory
    i_pmem_read = 1; i_pmem_address = 16'h0040;
    serve(3, {16{8'hA5}}, 0, wc, a0, a1, wr, wd, ir, dr, ird, drd);
    chk("t1_latency", 128'(wc), 128'd1);
    chk("t1_addr",    {112'd0, a0}, 128'h0040);
    chk("t1_write",   {127'd0, wr}, 128'd0);
    chk("t1_resps",   {126'd0, ir, dr}, 128'd2);
    chk("t1_rdata",   ird, {16{8'hA5}});
    i_pmem_read = 0;
    chk("t1_resp_one_cycle", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    chk("t1_idle_strobes",   {126'd0, pmem_read, pmem_write},    128'd0);
    @(negedge clk);

    // 2: simultaneous I read and D write; D first, then one IDLE cycle, then I
    i_pmem_read = 1; i_pmem_address = 16'h0080;
    d_pmem_write = 1; d_pmem_address = 16'h1000; d_pmem_wdata = {8{16'hDEAD}};
    serve(2, 128'h1111, 0, wc, a0, a1, wr, wd, ir, dr, ird, drd);
    chk("t2_d_addr",  {112'd0, a0}, 128'h1000);
    chk("t2_d_write", {127'd0, wr}, 128'd1);
    chk("t2_d_wdata", wd, {8{16'hDEAD}});
    chk("t2_d_resps", {126'd0, ir, dr}, 128'd1);
    chk("t2_d_drdata", drd, 128'h1111);
    d_pmem_write = 0;
    chk("t2_idle_gap", {126'd0, pmem_read, pmem_write}, 128'd0);
    serve(2, 128'h2222, 0, wc, a0, a1, wr, wd, ir, dr, ird, drd);
    chk("t2_i_latency", 128'(wc), 128'd1);
    chk("t2_i_addr",  {112'd0, a0}, 128'h0080);
    chk("t2_i_write", {127'd0, wr}, 128'd0);
    chk("t2_i_resps", {126'd0, ir, dr}, 128'd2);
    i_pmem_read = 0;
    @(negedge clk);

    // 3: starvation: I held while D keeps reading -> D,D,D,D,I,D
    exp_addr = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h0100, 16'h2000};
    exp_cnt  = '{1, 2, 3, 4, 0, 1};
    i_pmem_read = 1; i_pmem_address = 16'h0100;
    d_pmem_read = 1; d_pmem_address = 16'h2000;
    for (int k = 0; k < 6; k++) begin
      serve(2, 128'(k), 0, wc, a0, a1, wr, wd, ir, dr, ird, drd);
      chk($sformatf("t3_grant%0d_addr", k), {112'd0, a0}, 128'(exp_addr[k]));
      chk($sformatf("t3_grant%0d_cnt", k), {125'd0, dut.starve_cnt}, 128'(exp_cnt[k]));
      chk($sformatf("t3_grant%0d_resps", k), {126'd0, ir, dr},
          (exp_addr[k] == 16'h0100) ? 128'd2 : 128'd1);
    end
    i_pmem_read = 0; d_pmem_read = 0;
    @(negedge clk);
    // Leftover I service clears nothing here; counter still holds 1 with no grant
    chk("t3_cnt_hold", {125'd0, dut.starve_cnt}, 128'd1);

    // 4: D inputs change mid-transaction; latched values must hold
    d_pmem_read = 1; d_pmem_address = 16'h3000; d_pmem_wdata = 128'h1234;
    serve(4, 128'h5555, 1, wc, a0, a1, wr, wd, ir, dr, ird, drd);
    chk("t4_addr_start", {112'd0, a0}, 128'h3000);
    chk("t4_addr_end",   {112'd0, a1}, 128'h3000);
    chk("t4_wdata_hold", pmem_wdata, 128'h1234);
    chk("t4_read",       {127'd0, wr}, 128'd0);
    chk("t4_resps",      {126'd0, ir, dr}, 128'd1);
    d_pmem_read = 0;
    @(negedge clk);

    // 5: reset during SERVE_I aborts with no later resp
    i_pmem_read = 1; i_pmem_address = 16'h0500;
    @(negedge clk);
    chk("t5_serving", {127'd0, pmem_read}, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_read_drop", {127'd0, pmem_read}, 128'd0);
    chk("t5_state_rst", 128'(dut.state), 128'(ARB_IDLE));
    i_pmem_read = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("t5_no_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    @(negedge clk);
    pmem_resp = 1'b0;
    i_pmem_read = 1;
    serve(2, 128'hBEEF, 0, wc, a0, a1, wr, wd, ir, dr, ird, drd);
    chk("t5_reissue_addr",  {112'd0, a0}, 128'h0500);
    chk("t5_reissue_resps", {126'd0, ir, dr}, 128'd2);
    chk("t5_reissue_rdata", ird, 128'hBEEF);
    i_pmem_read = 0;
    @(negedge clk);

    // 6: spurious memory response while IDLE
    pmem_resp = 1'b1;
    #1;
    chk("t6_no_resp", {126'd0, i_pmem_resp, d_pmem_resp}, 128'd0);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("t6_state_idle", 128'(dut.state), 128'(ARB_IDLE));
    chk("t6_strobes",    {126'd0, pmem_read, pmem_write}, 128'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
